// File: rtl/fibo_pkg.sv
// Shared types and constants for the Fibonacci generator/index pair.
// Both blocks use the same IDLE/OP/DONE handshake state encoding.
package fibo_pkg;

    localparam int FIBO_W     = 20;
    localparam int FIBO_NW    = 5;
    localparam int FIBO_MAX_N = 30;

    typedef enum logic [1:0] {
        IDLE,
        OP,
        DONE
    } fibo_state_t;

endpackage

// File: rtl/fibo_index.sv
// Inverse Fibonacci: finds the largest n with F(n) <= v, F(0)=0, F(1)=1.
// Multi-cycle start/ready/done_tick FSM, one Fibonacci step per OP cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     request, sampled only while ready
//   v         value to search, latched when start is accepted
//   ready     high exactly while idle
//   done_tick one-cycle pulse when the result is complete
//   n         result index
//   f         F(n)
//   exact     1 when F(n) == v
//   rem       v - F(n), only when FIBO_INDEX_REM_EN is defined
//
// Optional feature macro: FIBO_INDEX_REM_EN (adds the rem output).
module fibo_index
    import fibo_pkg::*;
#(
    parameter int W  = FIBO_W,
    parameter int NW = FIBO_NW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  v,
    output logic          ready,
    output logic          done_tick,
    output logic [NW-1:0] n,
    output logic [W-1:0]  f,
    output logic          exact
`ifdef FIBO_INDEX_REM_EN
    ,
    output logic [W-1:0]  rem
`endif
);

    fibo_state_t state_q;
    fibo_state_t state_d;

    logic [W-1:0]  v_q;
    logic [W-1:0]  v_d;
    logic [W-1:0]  t0_q;
    logic [W-1:0]  t0_d;
    logic [W-1:0]  t1_q;
    logic [W-1:0]  t1_d;
    logic [NW-1:0] n_d;
    logic [W-1:0]  f_d;
    logic          exact_d;
`ifdef FIBO_INDEX_REM_EN
    logic [W-1:0]  rem_d;
`endif

    // One extra bit so t0+t1 never wraps and the compare against v
    // stays correct even when the next term no longer fits in W bits.
    logic [W:0] nxt;
    logic       v_zero;
    logic       past;

    assign nxt    = {1'b0, t0_q} + {1'b0, t1_q};
    assign v_zero = (v_q == '0);
    assign past   = (nxt > {1'b0, v_q});

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = OP;
            OP:   if (v_zero || past) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode, from the state register only
    always_comb begin
        ready     = 1'b0;
        done_tick = 1'b0;
        unique case (1'b1)
            (state_q == IDLE): ready     = 1'b1;
            (state_q == DONE): done_tick = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        v_d     = v_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        n_d     = n;
        f_d     = f;
        exact_d = exact;
`ifdef FIBO_INDEX_REM_EN
        rem_d   = rem;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    v_d  = v;
                    t0_d = '0;
                    t1_d = W'(1);
                    n_d  = NW'(1);
                end
            end
            OP: begin
                if (v_zero) begin
                    n_d     = '0;
                    f_d     = '0;
                    exact_d = 1'b1;
`ifdef FIBO_INDEX_REM_EN
                    rem_d   = '0;
`endif
                end else if (past) begin
                    // t1 is F(n): the largest term not above v.
                    f_d     = t1_q;
                    exact_d = (t1_q == v_q);
`ifdef FIBO_INDEX_REM_EN
                    rem_d   = v_q - t1_q;
`endif
                end else begin
                    t0_d = t1_q;
                    t1_d = nxt[W-1:0];
                    n_d  = n + NW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            t0_q  <= '0;
            t1_q  <= '0;
            n     <= '0;
            f     <= '0;
            exact <= 1'b0;
`ifdef FIBO_INDEX_REM_EN
            rem   <= '0;
`endif
        end else begin
            v_q   <= v_d;
            t0_q  <= t0_d;
            t1_q  <= t1_d;
            n     <= n_d;
            f     <= f_d;
            exact <= exact_d;
`ifdef FIBO_INDEX_REM_EN
            rem   <= rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_fibo_index.sv
// Self-checking bench for fibo_index: directed cases plus random values
// checked against a table-lookup reference of the Fibonacci sequence.
module tb_fibo_index;
    import fibo_pkg::*;

    localparam int W  = FIBO_W;
    localparam int NW = FIBO_NW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  v;
    logic          ready;
    logic          done_tick;
    logic [NW-1:0] n;
    logic [W-1:0]  f;
    logic          exact;
`ifdef FIBO_INDEX_REM_EN
    logic [W-1:0]  rem;
`endif

    int vectors = 0;
    int miscompares = 0;

    fibo_index #(.W(W), .NW(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .v         (v),
        .ready     (ready),
        .done_tick (done_tick),
        .n         (n),
        .f         (f),
        .exact     (exact)
`ifdef FIBO_INDEX_REM_EN
        ,
        .rem       (rem)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference: largest n with F(n) <= val, from a table of terms.
    task automatic ref_model(input logic [W-1:0] val, output int rn,
                             output longint rf, output logic rx);
        longint fib [0:40];
        fib[0] = 0;
        fib[1] = 1;
        for (int i = 2; i <= 40; i++) fib[i] = fib[i-1] + fib[i-2];
        rn = 0;
        for (int i = 0; i <= 40; i++) if (fib[i] <= longint'(val)) rn = i;
        rf = fib[rn];
        rx = (fib[rn] == longint'(val));
    endtask

    // Waits (bounded) for ready, then drives start/v on a falling edge
    // and steps to the first falling edge after the accepting edge.
    task automatic launch(input logic [W-1:0] val, input bit hold);
        int w = 0;
        while (!ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        chk("ready_wait", 64'(ready), 64'(1));
        start = 1'b1;
        v = val;
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk("busy_ready", 64'(ready), 64'(0));
    endtask

    // Counts OP cycles until done_tick (bounded) and checks the result.
    // pre = OP cycles already stepped over by the caller.
    task automatic finish_check(input logic [W-1:0] val, input int pre,
                                input string tag);
        int     cnt = pre;
        int     rn;
        longint rf;
        logic   rx;
        int     ops;
        ref_model(val, rn, rf, rx);
        ops = (val == 0) ? 1 : rn;
        while (!done_tick && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_ops"}, 64'(cnt), 64'(ops));
        chk({tag, "_done"}, 64'(done_tick), 64'(1));
        chk({tag, "_n"}, 64'(n), 64'(rn));
        chk({tag, "_f"}, 64'(f), 64'(rf));
        chk({tag, "_exact"}, 64'(exact), 64'(rx));
`ifdef FIBO_INDEX_REM_EN
        chk({tag, "_rem"}, 64'(rem), 64'(longint'(val) - rf));
`endif
    endtask

    task automatic after_done(input logic [W-1:0] val, input string tag);
        int     rn;
        longint rf;
        logic   rx;
        ref_model(val, rn, rf, rx);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(done_tick), 64'(0));
        chk({tag, "_idle"}, 64'(ready), 64'(1));
        chk({tag, "_hold_n"}, 64'(n), 64'(rn));
        chk({tag, "_hold_f"}, 64'(f), 64'(rf));
    endtask

    task automatic run(input logic [W-1:0] val, input string tag);
        launch(val, 1'b0);
        finish_check(val, 0, tag);
        after_done(val, tag);
    endtask

    initial begin
        logic [W-1:0] rv;
        int           seen;

        rst = 1'b1;
        start = 1'b0;
        v = '0;
        #1;
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_done", 64'(done_tick), 64'(0));
        chk("rst_n", 64'(n), 64'(0));
        chk("rst_f", 64'(f), 64'(0));
        chk("rst_exact", 64'(exact), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(W'(0), "v0");
        run(W'(1), "v1");
        run(W'(100), "v100");
        run(W'(2), "v2");
        run(W'(3), "v3");

        // start held high through two back-to-back runs
        launch(W'(832040), 1'b1);
        finish_check(W'(832040), 0, "max_exact");
        v = W'(1048575);
        @(negedge clk);
        chk("held_idle", 64'(ready), 64'(1));
        chk("held_keep_n", 64'(n), 64'(30));
        launch(W'(1048575), 1'b0);
        finish_check(W'(1048575), 0, "max_all1");
        after_done(W'(1048575), "max_all1");

        // start during OP is ignored
        launch(W'(100), 1'b0);
        start = 1'b1;
        v = W'(5);
        @(negedge clk);
        start = 1'b0;
        finish_check(W'(100), 1, "busy_start");
        after_done(W'(100), "busy_start");

        // v changes after acceptance
        launch(W'(21), 1'b0);
        v = W'(1000);
        finish_check(W'(21), 0, "v_change");
        after_done(W'(21), "v_change");

        // asynchronous reset mid-operation
        launch(W'(500), 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 64'(ready), 64'(1));
        chk("midrst_done", 64'(done_tick), 64'(0));
        chk("midrst_n", 64'(n), 64'(0));
        chk("midrst_f", 64'(f), 64'(0));
        chk("midrst_exact", 64'(exact), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_tick || !ready) seen++;
        end
        chk("midrst_quiet", 64'(seen), 64'(0));

        // random values, biased half toward small magnitudes
        for (int i = 0; i < 24; i++) begin
            if (i[0]) rv = W'($urandom_range(0, 200));
            else rv = W'($urandom);
            run(rv, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fibo_index.md
Name: fibo_index

Overview:
- Inverse of the Fibonacci generator. Given a W-bit value v, it finds the largest index n such that F(n) <= v, with F(0)=0 and F(1)=1.
- Reports n, the value F(n), and whether v is exactly a Fibonacci number.
- Multi-cycle FSM with the same start/ready/done_tick handshake as the generator. It sits beside the generator in the same datapath, so the pair can round-trip values.

Parameters:
- W, 20, data width of v and f.
- NW, 5, index width. Must hold the largest index whose F fits in W bits: 30 for W=20.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request. Sampled only in idle.
- v  input  W  value to search. Sampled on the cycle start is accepted.
- ready  output  1  high exactly while in idle.
- done_tick  output  1  one-cycle pulse in done state.
- n  output  NW  result index.
- f  output  W  F(n).
- exact  output  1  1 when F(n) == v.

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-operation. After reset:
  - state=idle, so ready=1 and done_tick=0.
  - n=0, f=0, exact=0.
  - Internal t0, t1 and the latched v are all 0.
- States:
  - idle:
    - ready=1.
    - On start: latch v, then set t0=0, t1=1, n=1, and go to op.
    - start in any other state is ignored.
  - op, with nxt = t0 + t1 computed at W+1 bits so it cannot wrap:
    - If latched v == 0: set n=0, f=0, exact=1, go to done.
    - Else if nxt > v (W+1-bit compare): set f=t1, exact=(t1==v), go to done. n stays.
    - Else: t0<=t1, t1<=nxt[W-1:0], n<=n+1, stay in op.
  - done: done_tick=1 for one cycle, then go to idle unconditionally.
- Latency from the start-accept edge:
  - Op cycles = final n for v>=1; 1 op cycle for v=0.
  - Then 1 done cycle.
- For v=1 the loop steps past the duplicate F(1)=F(2)=1 and returns n=2. This largest-index rule is intended.
- Outputs n, f and exact:
  - Are valid from the done cycle onward.
  - Hold until the next start is accepted.
  - Intermediate values are visible during op; consumers must qualify on done_tick or ready.
- v may change freely after acceptance; only the latched copy is used.
- Overflow: for W=20 the largest result is n=30 (F(30)=832040). F(31) at 21 bits always exceeds any 20-bit v, so there is no wrap and n never exceeds 30.
- All next-state logic is combinational with defaults assigned at the top, so there are no latches. ready and done_tick are decoded from the state register only.

Optional Feature:
- Macro FIBO_INDEX_REM_EN.
- Defined:
  - Adds output port rem, W bits, = v_latched - f.
  - rem is registered in the same cycle f is set and holds with n.
  - rem resets to 0.
  - rem is 0 whenever exact=1.
- Undefined: no rem port, subtractor and register, and all other behaviour is identical.

Decomposition:
- Package fibo_pkg holds:
  - typedef enum logic [1:0] fibo_state_t {IDLE, OP, DONE}, shared with the generator.
  - localparam FIBO_W=20 and FIBO_NW=5.
  - localparam FIBO_MAX_N=30.
- Single module; no sub-module is warranted. The add/compare step is a few lines of combinational logic.

Test Plan:
- v=0, pulse start:
  - ready drops the next cycle; 1 op cycle; done_tick pulses.
  - n=0, f=0, exact=1, rem=0.
- v=1: n=2, f=1, exact=1, done_tick after 2 op cycles.
- v=100: n=11, f=89, exact=0, rem=11; 11 op cycles.
- v=832040 then v=1048575, back-to-back, with start held high through both runs:
  - First run: n=30, f=832040, exact=1.
  - Second run starts only after ready returns. Result: n=30, f=832040, exact=0, rem=216535. No wrap to small n.
- Busy and reset:
  - Start v=100, pulse start again with v=5 during op: ignored, result is still n=11.
  - Start v=500, assert rst mid-op: immediately ready=1, done_tick=0, n=0, f=0, exact=0, with no spurious done_tick after release.
- v changes mid-op: start v=21, change v to 1000 on the next cycle. Result is n=8, f=21, exact=1.
